// File: rtl/ps2_kbd_pkg.sv
// Shared constants and types for the PS/2 keyboard front end.
// Holds the special scan codes, the receiver state encoding and a parity helper.
package ps2_kbd_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BAT   = 8'hAA;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // A frame is good when data plus parity bit hold an odd number of ones.
  function automatic logic parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_keymap.sv
// Scan-code to PET key-matrix position ROM.
// The index is {ext, code}; ext selects the E0 page (cursor and keypad keys).
// Anything not listed reports hit = 0, including E0 1A.
module ps2_keymap (
  input  logic       ext,
  input  logic [7:0] code,
  output logic       hit,
  output logic [3:0] row,
  output logic [2:0] col
);

  // Pure lookup table; unlisted codes fall through to a miss.
  always_comb begin
    hit = 1'b1;
    row = 4'd0;
    col = 3'd0;
    case ({ext, code})
      9'h01C: {row, col} = {4'd4, 3'd0};
      9'h032: {row, col} = {4'd6, 3'd2};
      9'h021: {row, col} = {4'd6, 3'd1};
      9'h023: {row, col} = {4'd4, 3'd1};
      9'h024: {row, col} = {4'd2, 3'd1};
      9'h02B: {row, col} = {4'd5, 3'd2};
      9'h034: {row, col} = {4'd4, 3'd3};
      9'h033: {row, col} = {4'd5, 3'd3};
      9'h043: {row, col} = {4'd3, 3'd5};
      9'h03B: {row, col} = {4'd4, 3'd4};
      9'h042: {row, col} = {4'd5, 3'd4};
      9'h04B: {row, col} = {4'd4, 3'd5};
      9'h03A: {row, col} = {4'd6, 3'd4};
      9'h031: {row, col} = {4'd7, 3'd3};
      9'h044: {row, col} = {4'd2, 3'd6};
      9'h04D: {row, col} = {4'd3, 3'd6};
      9'h015: {row, col} = {4'd2, 3'd0};
      9'h02D: {row, col} = {4'd2, 3'd2};
      9'h01B: {row, col} = {4'd5, 3'd0};
      9'h02C: {row, col} = {4'd3, 3'd2};
      9'h03C: {row, col} = {4'd2, 3'd4};
      9'h02A: {row, col} = {4'd7, 3'd2};
      9'h01D: {row, col} = {4'd3, 3'd0};
      9'h022: {row, col} = {4'd7, 3'd1};
      9'h035: {row, col} = {4'd3, 3'd3};
      9'h01A: {row, col} = {4'd7, 3'd0};
      9'h016: {row, col} = {4'd0, 3'd0};
      9'h01E: {row, col} = {4'd1, 3'd0};
      9'h026: {row, col} = {4'd0, 3'd1};
      9'h025: {row, col} = {4'd1, 3'd1};
      9'h029: {row, col} = {4'd9, 3'd2};
      9'h05A: {row, col} = {4'd6, 3'd5};
      9'h066: {row, col} = {4'd1, 3'd7};
      9'h012: {row, col} = {4'd8, 3'd0};
      9'h059: {row, col} = {4'd8, 3'd5};
      9'h076: {row, col} = {4'd9, 3'd4};
      9'h175: {row, col} = {4'd0, 3'd6};
      9'h172: {row, col} = {4'd1, 3'd6};
      9'h16B: {row, col} = {4'd0, 3'd5};
      9'h174: {row, col} = {4'd0, 3'd7};
      9'h16C: {row, col} = {4'd0, 3'd4};
      9'h171: {row, col} = {4'd1, 3'd5};
      9'h170: {row, col} = {4'd1, 3'd4};
      9'h14A: {row, col} = {4'd3, 3'd7};
      9'h15A: {row, col} = {4'd2, 3'd7};
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_keymatrix.sv
// PS/2 keyboard front end for the PET key matrix.
// Filters and deserialises PS/2 frames, decodes F0/E0 prefixes and keeps an
// active-low row/column matrix that the PIA reads through keyrow/keyin.
module ps2_keymatrix
  import ps2_kbd_pkg::*;
#(
  parameter int NUM_ROWS    = 16,
  parameter int ROW_BITS    = 4,
  parameter int ROW_WIDTH   = 8,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  input  logic [ROW_BITS-1:0]  keyrow,
  output logic [ROW_WIDTH-1:0] keyin,
  input  logic                 kbd_clr,
  output logic [7:0]           code,
  output logic                 code_valid,
  output logic                 code_err
);

  localparam int FILT_BITS = $clog2(FILTER_LEN + 1);
  localparam int TO_BITS   = $clog2(TIMEOUT_CYC + 1);
  localparam int MAT_BITS  = NUM_ROWS * ROW_WIDTH;
  localparam logic [FILT_BITS-1:0] FILT_LAST = FILT_BITS'(FILTER_LEN - 1);
  localparam logic [TO_BITS-1:0]   TO_LAST   = TO_BITS'(TIMEOUT_CYC - 1);

  logic [1:0]           clk_sync;
  logic [1:0]           data_sync;
  logic                 clk_s;
  logic                 data_s;
  logic                 filt_level;
  logic [FILT_BITS-1:0] filt_cnt;
  logic                 fall_edge;

  rx_state_t            state, state_n;
  logic [2:0]           bit_cnt, bit_cnt_n;
  logic [7:0]           shift, shift_n;
  logic                 par_bit, par_n;
  logic [TO_BITS-1:0]   to_cnt, to_cnt_n;
  logic                 rx_good;
  logic                 rx_err;

  logic                 brk;
  logic                 ext;
  logic [MAT_BITS-1:0]  matrix;
  logic                 map_hit;
  logic [3:0]           map_row;
  logic [2:0]           map_col;
  logic                 is_prefix;
  logic                 map_ok;
  logic [MAT_BITS-1:0]  upd_mask;

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  // Two-stage synchronisers for the asynchronous PS/2 lines; idle level is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // A level change is only believed once it has persisted FILTER_LEN cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_level <= 1'b1;
      filt_cnt   <= '0;
    end else if (clk_s == filt_level) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FILT_LAST) begin
      filt_level <= clk_s;
      filt_cnt   <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign fall_edge = filt_level && !clk_s && (filt_cnt == FILT_LAST);

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RX_IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      to_cnt  <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
      par_bit <= par_n;
      to_cnt  <= to_cnt_n;
    end
  end

  // Frame sequencing, frame checking and the inter-edge watchdog.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    par_n     = par_bit;
    to_cnt_n  = to_cnt;
    rx_good   = 1'b0;
    rx_err    = 1'b0;
    case (state)
      RX_IDLE: begin
        to_cnt_n = '0;
        if (fall_edge && !data_s) begin
          state_n   = RX_DATA;
          bit_cnt_n = '0;
        end
      end
      RX_DATA: begin
        if (fall_edge) begin
          shift_n   = {data_s, shift[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = RX_PARITY;
        end
      end
      RX_PARITY: begin
        if (fall_edge) begin
          par_n   = data_s;
          state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (fall_edge) begin
          state_n = RX_IDLE;
          if (parity_ok(shift, par_bit) && data_s) rx_good = 1'b1;
          else                                     rx_err  = 1'b1;
        end
      end
      default: state_n = RX_IDLE;
    endcase
    if (state != RX_IDLE) begin
      if (fall_edge) begin
        to_cnt_n = '0;
      end else if (to_cnt == TO_LAST) begin
        state_n  = RX_IDLE;
        rx_err   = 1'b1;
        to_cnt_n = '0;
      end else begin
        to_cnt_n = to_cnt + 1'b1;
      end
    end
  end

  // Register the frame result so the strobes land one cycle after the stop edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      code       <= 8'h00;
      code_valid <= 1'b0;
      code_err   <= 1'b0;
    end else begin
      code_valid <= rx_good;
      code_err   <= rx_err;
      if (rx_good) code <= shift;
    end
  end

  ps2_keymap u_keymap (
    .ext  (ext),
    .code (code),
    .hit  (map_hit),
    .row  (map_row),
    .col  (map_col)
  );

  assign is_prefix = (code == PS2_BREAK) || (code == PS2_EXT);
  assign map_ok    = map_hit && !is_prefix &&
                     (int'(map_row) < NUM_ROWS) && (int'(map_col) < ROW_WIDTH);
  assign upd_mask  = map_ok ? (MAT_BITS'(1) << (int'(map_row) * ROW_WIDTH + int'(map_col)))
                            : '0;

  // Decode the byte presented with code_valid; kbd_clr overrides any matrix change.
  always_ff @(posedge clk) begin
    if (reset) begin
      brk    <= 1'b0;
      ext    <= 1'b0;
      matrix <= '1;
    end else begin
      if (code_err) begin
        brk <= 1'b0;
        ext <= 1'b0;
      end else if (code_valid) begin
        if (code == PS2_BREAK) begin
          brk <= 1'b1;
        end else if (code == PS2_EXT) begin
          ext <= 1'b1;
        end else begin
          brk <= 1'b0;
          ext <= 1'b0;
        end
      end
      if (kbd_clr) begin
        matrix <= '1;
      end else if (code_valid && (code == PS2_BAT)) begin
        matrix <= '1;
      end else if (code_valid && map_ok) begin
        matrix <= brk ? (matrix | upd_mask) : (matrix & ~upd_mask);
      end
    end
  end

  // Row readout for the PIA; rows beyond the matrix read as released.
  always_comb begin
    keyin = '1;
    if (int'(keyrow) < NUM_ROWS) keyin = ROW_WIDTH'(matrix >> (int'(keyrow) * ROW_WIDTH));
  end

endmodule

// File: tb/tb_ps2_keymatrix.sv
// Self-checking bench for ps2_keymatrix: bit-bangs PS/2 frames, queues the
// expected scan codes and compares each code_valid against the queue, and keeps
// a small model of the rows for the Z and T keys.
module tb_ps2_keymatrix;
  import ps2_kbd_pkg::*;

  localparam int HALF   = 20;
  localparam int TO_CYC = 1000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       kbd_clr = 1'b0;
  logic [3:0] keyrow = 4'd0;
  logic [7:0] keyin;
  logic [7:0] code;
  logic       code_valid;
  logic       code_err;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         err_seen = 0;
  int         err_exp = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_rows[16];
  logic       m_brk = 1'b0;
  logic       m_ext = 1'b0;
  logic       prev_valid = 1'b0;

  ps2_keymatrix #(.TIMEOUT_CYC(TO_CYC)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .keyrow     (keyrow),
    .keyin      (keyin),
    .kbd_clr    (kbd_clr),
    .code       (code),
    .code_valid (code_valid),
    .code_err   (code_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: every code_valid pops one expected byte; strobes must be single-cycle.
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (prev_valid) checkOutput("cv_pulse", {31'b0, code_valid}, 32'd0);
      if (code_valid) begin
        if (exp_q.size() == 0) checkOutput("unexp_valid", exp_q.size(), 32'd1);
        else                   checkOutput("code", {24'b0, code}, {24'b0, exp_q.pop_front()});
      end
      if (code_err) err_seen++;
      prev_valid = code_valid;
    end
  end

  task automatic sendBit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic bad_par);
    logic p;
    p = (~^b) ^ bad_par;
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(b[i]);
    sendBit(p);
    sendBit(1'b1);
    ps2_data = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic sendPartial(input int nbits);
    sendBit(1'b0);
    for (int i = 1; i < nbits; i++) sendBit(1'b1);
  endtask

  task automatic allRowsReleased();
    for (int r = 0; r < 16; r++) exp_rows[r] = 8'hFF;
  endtask

  task automatic modelDecode(input logic [7:0] b);
    if (b == PS2_BREAK) begin
      m_brk = 1'b1;
    end else if (b == PS2_EXT) begin
      m_ext = 1'b1;
    end else begin
      if (b == PS2_BAT)                 allRowsReleased();
      else if (!m_ext && b == 8'h1A)    exp_rows[7][0] = m_brk;
      else if (!m_ext && b == 8'h2C)    exp_rows[3][2] = m_brk;
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic bad_par);
    if (bad_par) begin
      err_exp++;
      m_brk = 1'b0;
      m_ext = 1'b0;
    end else begin
      exp_q.push_back(b);
      modelDecode(b);
    end
    sendFrame(b, bad_par);
    repeat (10) @(negedge clk);
  endtask

  task automatic checkRows(input string tag);
    for (int r = 0; r < 16; r++) begin
      @(negedge clk);
      keyrow = 4'(r);
      #1;
      checkOutput($sformatf("%s_row%0d", tag, r), {24'b0, keyin}, {24'b0, exp_rows[r]});
    end
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    allRowsReleased();
    repeat (5) @(negedge clk);
    checkOutput("rst_code", {24'b0, code}, 32'h00);
    checkOutput("rst_valid", {31'b0, code_valid}, 32'd0);
    checkOutput("rst_err", {31'b0, code_err}, 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checkRows("reset");

    applyStimulus(8'h1A, 1'b0);
    checkOutput("code_hold", {24'b0, code}, 32'h1A);
    checkRows("z_make");
    applyStimulus(8'hF0, 1'b0);
    applyStimulus(8'h1A, 1'b0);
    checkRows("z_break");

    applyStimulus(8'h1A, 1'b0);
    applyStimulus(8'h2C, 1'b0);
    checkRows("z_t");
    applyStimulus(8'h2C, 1'b0);
    applyStimulus(8'hF0, 1'b0);
    applyStimulus(8'h2C, 1'b0);
    checkRows("t_rel");

    applyStimulus(8'hF0, 1'b0);
    applyStimulus(8'h1A, 1'b0);
    applyStimulus(8'hE0, 1'b0);
    applyStimulus(8'h1A, 1'b0);
    checkRows("e0_1a");
    applyStimulus(8'h1A, 1'b0);
    checkRows("z_again");
    applyStimulus(8'hF0, 1'b0);
    applyStimulus(8'hF0, 1'b0);
    applyStimulus(8'h1A, 1'b0);
    checkRows("f0f0");

    applyStimulus(8'h1A, 1'b1);
    checkOutput("err_par", err_seen, err_exp);
    checkRows("bad_par");
    sendPartial(4);
    ps2_data = 1'b1;
    err_exp++;
    m_brk = 1'b0;
    m_ext = 1'b0;
    repeat (TO_CYC + 200) @(negedge clk);
    checkOutput("err_timeout", err_seen, err_exp);
    applyStimulus(8'h1A, 1'b0);
    checkRows("after_err");

    fork
      applyStimulus(8'h2C, 1'b0);
      begin
        for (int k = 0; k < 2000; k++) begin
          @(negedge clk);
          if (code_valid) break;
        end
        checkOutput("clr_sync", {31'b0, code_valid}, 32'd1);
        kbd_clr = 1'b1;
        @(negedge clk);
        kbd_clr = 1'b0;
      end
    join
    allRowsReleased();
    checkRows("kbd_clr");

    applyStimulus(8'h1A, 1'b0);
    applyStimulus(8'h2C, 1'b0);
    applyStimulus(8'hAA, 1'b0);
    checkRows("bat");

    applyStimulus(8'h1A, 1'b0);
    sendPartial(5);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    ps2_data = 1'b1;
    allRowsReleased();
    m_brk = 1'b0;
    m_ext = 1'b0;
    repeat (TO_CYC + 200) @(negedge clk);
    checkOutput("err_reset", err_seen, err_exp);
    checkOutput("code_reset", {24'b0, code}, 32'h00);
    checkRows("mid_reset");

    checkOutput("pending", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
